cruise_ctrl_fsm: RTL and testbench

Parametrised Moore-style longitudinal controller for the self-driving car datapath. It is the successor to the basic stop/accelerate/decelerate control unit. It adds a speed-dependent safe following distance, a CRUISE state with speed hysteresis, a latched EMERGENCY brake state and a driver engage input. Doors unlock only after a programmable dwell at standstill. It sits between the sensor front-end (speed and distance) and the actuator drivers (fuel, brake, door lock).

---
 rtl/cruise_ctrl_fsm.sv | 88 ++++++++
 tb/tb_cruise_ctrl_fsm.sv | 106 ++++++++++
 2 files changed

// File: rtl/cruise_ctrl_fsm.sv
// cruise_ctrl_fsm: Moore longitudinal controller with speed-dependent gap, cruise hysteresis,
// latched emergency braking and a standstill dwell before the doors unlock.
module cruise_ctrl_fsm #(
    parameter int SPEED_W        = 8,
    parameter int DIST_W         = 8,
    parameter int MIN_DISTANCE   = 40,
    parameter int SPEED_SHIFT    = 2,
    parameter int EMERG_DISTANCE = 10,
    parameter int HYST           = 2,
    parameter int STOP_DWELL     = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               engage,
    input  logic [SPEED_W-1:0] speed_limit,
    input  logic [SPEED_W-1:0] car_speed,
    input  logic [DIST_W-1:0]  leading_distance,
    output logic               unlock_doors,
    output logic               accelerate_car,
    output logic               brake_car,
    output logic               emergency_brake,
    output logic [2:0]         state_o
);
    localparam int CW = ($clog2(STOP_DWELL + 1) < 1) ? 1 : $clog2(STOP_DWELL + 1);
    localparam int AW = ((DIST_W > SPEED_W) ? DIST_W : SPEED_W) + 1;
    localparam logic [CW-1:0] DWELL = CW'(STOP_DWELL);

    typedef enum logic [2:0] {
        STOP       = 3'd0,
        ACCELERATE = 3'd1,
        CRUISE     = 3'd2,
        DECELERATE = 3'd3,
        EMERGENCY  = 3'd4
    } state_t;

    logic [2:0]    state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [AW-1:0] safe_dist;
    logic [SPEED_W:0] speed_h;
    logic far, emerg, z, over, low;

    assign safe_dist = AW'(MIN_DISTANCE) + AW'(car_speed >> SPEED_SHIFT);
    assign speed_h   = {1'b0, car_speed} + (SPEED_W + 1)'(HYST);
    assign far       = AW'(leading_distance) >= safe_dist;
    assign emerg     = leading_distance < DIST_W'(EMERG_DISTANCE);
    assign z         = car_speed == '0;
    assign over      = car_speed > speed_limit;
    assign low       = speed_h < {1'b0, speed_limit};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= STOP;
            cnt   <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
        end
    end

    always_comb begin
        state_n = STOP;
        cnt_n   = '0;
        case (state)
            STOP: begin
                state_n = (engage && far) ? ACCELERATE : STOP;
                cnt_n   = !z ? '0 : (cnt == DWELL) ? cnt : cnt + CW'(1);
            end
            ACCELERATE: state_n = emerg ? EMERGENCY :
                                  (!engage || !far || over) ? DECELERATE :
                                  !low ? CRUISE : ACCELERATE;
            CRUISE:     state_n = emerg ? EMERGENCY :
                                  (!engage || !far || over) ? DECELERATE :
                                  low ? ACCELERATE : CRUISE;
            DECELERATE: state_n = z ? STOP : emerg ? EMERGENCY :
                                  (engage && far && low) ? ACCELERATE :
                                  (engage && far && !over) ? CRUISE : DECELERATE;
            // Latched: only standstill releases the emergency brake.
            EMERGENCY:  state_n = z ? STOP : EMERGENCY;
            default:    state_n = STOP;
        endcase
    end

    assign unlock_doors    = (state == STOP) && (cnt == DWELL);
    assign accelerate_car  = state == ACCELERATE;
    assign brake_car       = (state == DECELERATE) || (state == EMERGENCY);
    assign emergency_brake = state == EMERGENCY;
    assign state_o         = state;
endmodule

// File: tb/tb_cruise_ctrl_fsm.sv
// tb_cruise_ctrl_fsm: directed checks of cruise_ctrl_fsm with hand-computed expected outputs.
module tb_cruise_ctrl_fsm;
    logic       clk, rst, engage;
    logic [7:0] speed_limit, car_speed, leading_distance;
    logic       unlock_doors, accelerate_car, brake_car, emergency_brake;
    logic [2:0] state_o;
    int tests = 0;
    int failed = 0;

    cruise_ctrl_fsm dut (
        .clk(clk), .rst(rst), .engage(engage), .speed_limit(speed_limit),
        .car_speed(car_speed), .leading_distance(leading_distance),
        .unlock_doors(unlock_doors), .accelerate_car(accelerate_car),
        .brake_car(brake_car), .emergency_brake(emergency_brake), .state_o(state_o)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    // Expected {unlock, accel, brake, emerg, state} for a legal state code.
    function automatic logic [6:0] ex(input int st, input bit unl);
        return {unl, st == 1, st == 3 || st == 4, st == 4, 3'(st)};
    endfunction

    function automatic logic [6:0] obs();
        return {unlock_doors, accelerate_car, brake_car, emergency_brake, state_o};
    endfunction

    task automatic chk(input string tag, input logic [6:0] o, input logic [6:0] e);
        tests++;
        assert (o === e) else begin
            failed++;
            $error("FAIL %s: observed %b expected %b", tag, o, e);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1; engage = 0; car_speed = 0; leading_distance = 100; speed_limit = 80;
        #1 chk("reset_t0", obs(), ex(0, 0));
        step(); step();
        chk("reset_held", obs(), ex(0, 0));
        @(negedge clk) rst = 0;
        step(); chk("dwell1", obs(), ex(0, 0));
        step(); chk("dwell2", obs(), ex(0, 0));
        step(); chk("dwell3", obs(), ex(0, 0));
        step(); chk("dwell4_unlock", obs(), ex(0, 1));
        step(); chk("dwell_sat", obs(), ex(0, 1));
        engage = 1; leading_distance = 39;
        step(); chk("launch_gap39", obs(), ex(0, 1));
        leading_distance = 100;
        step(); chk("launch", obs(), ex(1, 0));
        car_speed = 78;
        step(); chk("hyst_78_cruise", obs(), ex(2, 0));
        car_speed = 77;
        step(); chk("hyst_77_accel", obs(), ex(1, 0));
        car_speed = 81;
        step(); chk("over_81_decel", obs(), ex(3, 0));
        car_speed = 70;
        step(); chk("decel_70_accel", obs(), ex(1, 0));
        car_speed = 80;
        step(); chk("at_limit_cruise", obs(), ex(2, 0));
        leading_distance = 59;
        step(); chk("gap59_decel", obs(), ex(3, 0));
        leading_distance = 60; car_speed = 79;
        step(); chk("gap60_cruise", obs(), ex(2, 0));
        engage = 0;
        step(); chk("disengage_decel", obs(), ex(3, 0));
        car_speed = 0;
        step(); chk("standstill_stop", obs(), ex(0, 0));
        engage = 1; leading_distance = 100;
        step(); chk("relaunch", obs(), ex(1, 0));
        car_speed = 60; speed_limit = 60;
        step(); chk("cruise_60", obs(), ex(2, 0));
        leading_distance = 9;
        step(); chk("emerg_enter", obs(), ex(4, 0));
        leading_distance = 200;
        step(); chk("emerg_latch1", obs(), ex(4, 0));
        step(); chk("emerg_latch2", obs(), ex(4, 0));
        engage = 0; car_speed = 0;
        step(); chk("emerg_stop", obs(), ex(0, 0));
        step(); chk("edwell1", obs(), ex(0, 0));
        step(); chk("edwell2", obs(), ex(0, 0));
        step(); chk("edwell3", obs(), ex(0, 0));
        step(); chk("edwell4_unlock", obs(), ex(0, 1));
        engage = 1; leading_distance = 100;
        step(); chk("accel_again", obs(), ex(1, 0));
        #2 rst = 1;
        #1 chk("async_reset", obs(), ex(0, 0));
        #1 rst = 0; engage = 0;
        step(); chk("rdwell1", obs(), ex(0, 0));
        step(); chk("rdwell2", obs(), ex(0, 0));
        step(); chk("rdwell3", obs(), ex(0, 0));
        step(); chk("rdwell4_unlock", obs(), ex(0, 1));
        force dut.state = 3'd5;
        #1 chk("illegal_outputs", obs(), 7'b0000101);
        release dut.state;
        step(); chk("illegal_recover", {4'b0, state_o}, 7'd0);
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
